// File: rtl/prog_loader.sv
// Program-image loader: assembles a big-endian byte stream (word count, then words)
// into 32-bit program-RAM writes and acknowledges the host once the image is in.
module prog_loader #(
    parameter int         MEM      = 17,
    parameter logic [7:0] ACK_BYTE = 8'hAA
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            rx_valid,
    input  logic [7:0]      rx_data,
    output logic            we,
    output logic [MEM-3:0]  waddr,
    output logic [31:0]     wdata,
    output logic            tx_valid,
    output logic [7:0]      tx_data,
    input  logic            tx_ready,
    output logic            done,
    output logic            err
);

    localparam int              AW    = MEM - 2;
    localparam int              CW    = MEM - 1;
    localparam logic [32:0]     DEPTH = 33'(1) << AW;
    localparam logic [CW-1:0]   ONE   = CW'(1);

    typedef enum logic [2:0] {S_LEN, S_DATA, S_ACK, S_DONE, S_ERR} state_t;

    state_t         state, state_nxt;
    logic [1:0]     bcnt;
    logic [23:0]    shift;
    logic [CW-1:0]  widx;
    logic [CW-1:0]  nwords;
    logic [31:0]    word;
    logic           take;
    logic           last_byte;

    // The incoming byte completes the big-endian word formed with the three held bytes.
    assign word      = {shift, rx_data};
    assign last_byte = take && (bcnt == 2'd3);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_LEN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            S_LEN: begin
                take = rx_valid;
                if (rx_valid && bcnt == 2'd3) begin
                    if (word == 32'd0) begin
                        state_nxt = S_ACK;
                    end else if ({1'b0, word} > DEPTH) begin
                        state_nxt = S_ERR;
                    end else begin
                        state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                take = rx_valid;
                // N never exceeds the depth, so widx+1 cannot wrap in CW bits.
                if (rx_valid && bcnt == 2'd3 && (widx + ONE) == nwords) begin
                    state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                tx_valid = 1'b1;
                tx_data  = ACK_BYTE;
                if (tx_ready) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: done = 1'b1;
            S_ERR:  err  = 1'b1;
            default: state_nxt = S_LEN;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bcnt   <= 2'd0;
            shift  <= 24'd0;
            widx   <= '0;
            nwords <= '0;
            we     <= 1'b0;
            waddr  <= '0;
            wdata  <= 32'd0;
        end else begin
            we <= 1'b0;
            if (take) begin
                shift <= word[23:0];
                bcnt  <= bcnt + 2'd1;
            end
            if (last_byte && state == S_LEN) begin
                nwords <= word[CW-1:0];
            end
            if (last_byte && state == S_DATA) begin
                we    <= 1'b1;
                waddr <= widx[AW-1:0];
                wdata <= word;
                widx  <= widx + ONE;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: stream-level reference model feeds a scoreboard of expected
// RAM writes and ack bytes; a negedge monitor checks everything the DUT emits.
module tb_prog_loader;

    localparam int MEM   = 17;
    localparam int AW    = MEM - 2;
    localparam int DEPTH = 1 << AW;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           rx_valid = 1'b0;
    logic [7:0]     rx_data = 8'h00;
    logic           tx_ready = 1'b1;
    logic           we;
    logic [AW-1:0]  waddr;
    logic [31:0]    wdata;
    logic           tx_valid;
    logic [7:0]     tx_data;
    logic           done;
    logic           err;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    int     txv_cycles = 0;

    typedef struct {
        int          addr;
        logic [31:0] data;
        longint      cyc;
    } wr_t;

    wr_t        wr_q[$];
    logic [7:0] ack_q[$];

    prog_loader #(.MEM(MEM), .ACK_BYTE(8'hAA)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Monitor: every write and every completed ack handshake must match the scoreboard.
    always @(negedge clk) begin
        if (rstn) begin
            if (tx_valid) txv_cycles++;
            if (we) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", {1'b1, waddr}, 0);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    check("waddr", waddr, e.addr);
                    check("wdata", wdata, e.data);
                    check("we_cycle", cyc, e.cyc);
                end
            end
            if (tx_valid && tx_ready) begin
                if (ack_q.size() == 0) begin
                    check("unexpected_ack", {1'b1, tx_data}, 0);
                end else begin
                    logic [7:0] a;
                    a = ack_q.pop_front();
                    check("ack_byte", tx_data, a);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) step();
        rx_valid = 1'b1;
        rx_data  = b;
        step();
        rx_valid = 1'b0;
    endtask

    // Reference model: the first four bytes are N; word k occupies bytes 4+4k..7+4k.
    // A word is written (one cycle after its last byte) only if the image fits and k < N.
    task automatic load(input logic [7:0] bytes[$], input int maxgap);
        logic [31:0] n;
        bit          fits;
        int          k;
        n    = {bytes[0], bytes[1], bytes[2], bytes[3]};
        fits = (n <= DEPTH);
        if (fits) ack_q.push_back(8'hAA);
        for (int i = 0; i < bytes.size(); i++) begin
            int gap;
            gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            repeat (gap) step();
            k = i / 4 - 1;
            if (fits && i >= 4 && (i % 4) == 3 && k < int'(n)) begin
                wr_t e;
                e.addr = k;
                e.data = {bytes[i-3], bytes[i-2], bytes[i-1], bytes[i]};
                e.cyc  = cyc + 1;
                wr_q.push_back(e);
            end
            send_byte(bytes[i], 0);
        end
    endtask

    task automatic do_reset();
        rstn     = 1'b0;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        #1;
        check("reset_outputs", {we, waddr, wdata, tx_valid, tx_data, done, err}, 0);
        repeat (2) step();
        check("reset_outputs_held", {we, waddr, wdata, tx_valid, tx_data, done, err}, 0);
        wr_q.delete();
        ack_q.delete();
        txv_cycles = 0;
        rstn = 1'b1;
        step();
    endtask

    task automatic wait_end(input string name, input bit exp_done, input bit exp_err);
        int t;
        t = 0;
        while (!(done || err) && t < 400) begin
            step();
            t++;
        end
        if (t >= 400) check({name, "_timeout"}, 1, 0);
        repeat (3) step();
        check({name, "_done"}, done, exp_done);
        check({name, "_err"}, err, exp_err);
        check({name, "_writes_left"}, wr_q.size(), 0);
        check({name, "_acks_left"}, ack_q.size(), 0);
    endtask

    function automatic void rand_image(output logic [7:0] q[$], input int n);
        q = {};
        q.push_back(8'(n >> 24));
        q.push_back(8'(n >> 16));
        q.push_back(8'(n >> 8));
        q.push_back(8'(n));
        for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
    endfunction

    initial begin
        logic [7:0] img[$];

        // Gapless 2-word load
        do_reset();
        img = '{8'h00, 8'h00, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                8'h01, 8'h23, 8'h45, 8'h67};
        load(img, 0);
        wait_end("two_word", 1'b1, 1'b0);
        check("two_word_txv_cycles", txv_cycles, 1);

        // Empty image
        do_reset();
        img = '{8'h00, 8'h00, 8'h00, 8'h00};
        load(img, 0);
        wait_end("empty", 1'b1, 1'b0);

        // Overflow: N = 65536, then extra bytes that must be ignored
        do_reset();
        img = '{8'h00, 8'h01, 8'h00, 8'h00};
        for (int i = 0; i < 8; i++) img.push_back(8'($urandom));
        load(img, 0);
        wait_end("overflow", 1'b0, 1'b1);
        check("overflow_txv_cycles", txv_cycles, 0);

        // Overflow boundary: N = depth + 1
        do_reset();
        img = '{8'h00, 8'h00, 8'h80, 8'h01};
        load(img, 2);
        wait_end("depth_plus1", 1'b0, 1'b1);

        // Backpressure on the ack with stray rx bytes in S_ACK and S_DONE
        do_reset();
        tx_ready = 1'b0;
        rand_image(img, 1);
        load(img, 0);
        begin
            int t;
            t = 0;
            while (!tx_valid && t < 20) begin
                step();
                t++;
            end
        end
        for (int i = 0; i < 10; i++) begin
            check("bp_tx_valid", tx_valid, 1);
            check("bp_tx_data", tx_data, 8'hAA);
            check("bp_done_low", done, 0);
            send_byte(8'($urandom), 0);
        end
        tx_ready = 1'b1;
        wait_end("backpressure", 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) send_byte(8'($urandom), int'($urandom_range(2, 0)));
        repeat (3) step();
        check("after_done_done", done, 1);
        check("after_done_txv_cycles", txv_cycles, 11);

        // 3-word load with random 0..20 idle cycles between bytes
        do_reset();
        rand_image(img, 3);
        load(img, 20);
        wait_end("random_gaps", 1'b1, 1'b0);

        // Several random loads of random size
        for (int r = 0; r < 4; r++) begin
            do_reset();
            rand_image(img, int'($urandom_range(6, 1)));
            load(img, int'($urandom_range(3, 0)));
            wait_end("random_load", 1'b1, 1'b0);
        end

        // Reset mid-load, then a clean 1-word load
        do_reset();
        img = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h11, 8'h22};
        foreach (img[i]) send_byte(img[i], 1);
        rstn = 1'b0;
        #1;
        check("midload_reset_outputs", {we, waddr, wdata, tx_valid, tx_data, done, err}, 0);
        repeat (3) step();
        rstn = 1'b1;
        step();
        txv_cycles = 0;
        img = '{8'h00, 8'h00, 8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
        load(img, 1);
        wait_end("after_reset", 1'b1, 1'b0);
        check("after_reset_txv_cycles", txv_cycles, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
